// File: rtl/apb_slave_ws.sv
// apb_slave_ws: APB slave word memory with fixed wait states, byte strobes and read-only low words
module apb_slave_ws #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1,
    parameter int RO_WORDS    = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSELx,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << LB) - 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_READY = 2'd2;

    logic [1:0]            state, nxt;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] idx;
    logic [IW-1:0]         idx_q, cur_idx;
    logic                  write_q, err_q, ro_hit, err_in, setup, cur_wr, cur_err, commit;
    logic [DATA_WIDTH-1:0] wdata_q, bmask;
    logic [NB-1:0]         strb_q;
    logic [DATA_WIDTH-1:0] rd_words [MEM_DEPTH];

    assign idx = PADDR >> LB;

    if (RO_WORDS > 0) begin : g_ro
        assign ro_hit = idx < ADDR_WIDTH'(RO_WORDS);
    end else begin : g_rw
        assign ro_hit = 1'b0;
    end

    assign err_in  = (idx >= ADDR_WIDTH'(MEM_DEPTH)) || (|(PADDR & OFF_MASK)) || (PWRITE && ro_hit);
    assign setup   = (state == S_IDLE) && PSELx && !PENABLE;
    assign cur_idx = (state == S_IDLE) ? idx[IW-1:0] : idx_q;
    assign cur_wr  = (state == S_IDLE) ? PWRITE : write_q;
    assign cur_err = (state == S_IDLE) ? err_in : err_q;
    assign commit  = (state == S_READY) && PSELx && write_q && !err_q;
    assign PREADY  = state == S_READY;
    assign PSLVERR = (state == S_READY) && err_q;

    assign nxt = (state == S_IDLE) ? (setup ? (WAIT_STATES == 0 ? S_READY : S_WAIT) : S_IDLE)
               : (state == S_WAIT) ? (!PSELx ? S_IDLE : (PENABLE && cnt == 4'd1) ? S_READY : S_WAIT)
               : S_IDLE;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < NB; b++) bmask[8*b +: 8] = {8{strb_q[b]}};
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            PRDATA  <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state  <= nxt;
            PRDATA <= (nxt == S_READY && !cur_wr && !cur_err) ? rd_words[cur_idx] : '0;
            if (setup) begin
                idx_q   <= idx[IW-1:0];
                write_q <= PWRITE;
                err_q   <= err_in;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
                cnt     <= 4'(WAIT_STATES);
            end else if (state == S_WAIT && PSELx && PENABLE) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    for (genvar w = 0; w < MEM_DEPTH; w++) begin : g_mem
        logic [DATA_WIDTH-1:0] word;
        always_ff @(posedge PCLK) begin
            if (!PRESETn) word <= '0;
            else if (commit && idx_q == IW'(w)) word <= (word & ~bmask) | (wdata_q & bmask);
        end
        assign rd_words[w] = word;
    end
endmodule

// File: tb/tb_apb_slave_ws.sv
// tb_apb_slave_ws: three differently configured slaves driven by directed and random transfers against a word-array model
module tb_apb_slave_ws;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [2:0]  psel = '0;
    logic        PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr [3];

    int ws [3] = '{1, 0, 3};
    int ro [3] = '{0, 4, 0};
    logic [31:0] m [3][256];
    int tests = 0, fails = 0;

    always #5 PCLK = ~PCLK;

    apb_slave_ws u0 (.PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
    apb_slave_ws #(.WAIT_STATES(0), .RO_WORDS(4)) u1 (.PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[1]),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
    apb_slave_ws #(.WAIT_STATES(3)) u2 (.PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[2]), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[2]),
        .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 256; i++) m[d][i] = '0;
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er, output int lows);
        psel = '0;
        psel[d] = 1'b1;
        PENABLE = 1'b0;
        PWRITE = wr;
        PADDR = a;
        PWDATA = wd;
        PSTRB = st;
        step();
        PENABLE = 1'b1;
        lows = 0;
        while (!pready[d] && lows < 40) begin
            chk("slverr_while_low", {31'b0, pslverr[d]}, 32'd0);
            step();
            lows++;
        end
        rd = prdata[d];
        er = pslverr[d];
        step();
        psel = '0;
        PENABLE = 1'b0;
    endtask

    task automatic op(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd);
        logic er;
        int lows, i;
        bit e;
        logic [31:0] exp_rd;
        i = int'(a >> 2);
        e = (i >= 256) || (a[1:0] != 2'b00) || (wr && i < ro[d]);
        exp_rd = (wr || e) ? 32'd0 : m[d][i];
        xfer(d, wr, a, wd, st, rd, er, lows);
        chk("wait_cycles", lows, ws[d]);
        chk("slverr", {31'b0, er}, {31'b0, e});
        chk("rdata", rd, exp_rd);
        chk("rdata_after", prdata[d], 32'd0);
        if (wr && !e)
            for (int b = 0; b < 4; b++)
                if (st[b]) m[d][i][8*b +: 8] = wd[8*b +: 8];
    endtask

    initial begin
        logic [31:0] rd, a;
        int r, i;
        clear_model();
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            chk("rst_prdata", prdata[d], 32'd0);
            chk("rst_pready", {31'b0, pready[d]}, 32'd0);
            chk("rst_pslverr", {31'b0, pslverr[d]}, 32'd0);
        end
        PRESETn = 1'b1;
        step();

        op(0, 1, 32'h28, 32'hDEADBEEF, 4'hF, rd);
        op(0, 0, 32'h28, 32'h0, 4'h0, rd);
        chk("basic_read", rd, 32'hDEADBEEF);

        op(0, 1, 32'h40, 32'h11223344, 4'hF, rd);
        op(0, 1, 32'h40, 32'hAABBCCDD, 4'h5, rd);
        op(0, 0, 32'h40, 32'h0, 4'h0, rd);
        chk("strobe_merge", rd, 32'h11BB33DD);
        op(0, 1, 32'h40, 32'hFFFFFFFF, 4'h0, rd);
        op(0, 0, 32'h40, 32'h0, 4'h0, rd);
        chk("strobe_none", rd, 32'h11BB33DD);

        op(0, 0, 32'h400, 32'h0, 4'h0, rd);
        op(0, 1, 32'h41, 32'h55555555, 4'hF, rd);
        op(0, 0, 32'h40, 32'h0, 4'h0, rd);
        chk("misaligned_untouched", rd, 32'h11BB33DD);

        op(1, 1, 32'h8, 32'h5, 4'hF, rd);
        op(1, 0, 32'h8, 32'h0, 4'h0, rd);
        chk("ro_readback", rd, 32'h0);
        op(1, 1, 32'h10, 32'h5, 4'hF, rd);
        op(1, 0, 32'h10, 32'h0, 4'h0, rd);
        chk("rw_readback", rd, 32'h5);
        op(2, 1, 32'h10, 32'h77, 4'hF, rd);
        op(2, 0, 32'h10, 32'h0, 4'h0, rd);
        chk("ws3_readback", rd, 32'h77);

        psel = 3'b001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h20; PWDATA = 32'h12345678; PSTRB = 4'hF;
        step();
        chk("abort_wait_low", {31'b0, pready[0]}, 32'd0);
        psel = '0;
        step();
        op(0, 0, 32'h20, 32'h0, 4'h0, rd);
        chk("abort_wait_word", rd, 32'h0);

        psel = 3'b010; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h24; PWDATA = 32'h9ABCDEF0; PSTRB = 4'hF;
        step();
        chk("abort_ready_hi", {31'b0, pready[1]}, 32'd1);
        psel = '0;
        step();
        op(1, 0, 32'h24, 32'h0, 4'h0, rd);
        chk("abort_ready_word", rd, 32'h0);

        psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h2C; PWDATA = 32'h0F0F0F0F; PSTRB = 4'hF;
        step();
        PENABLE = 1'b1;
        step();
        psel = '0;
        PENABLE = 1'b0;
        step();
        op(2, 0, 32'h2C, 32'h0, 4'h0, rd);
        chk("abort_ws3_word", rd, 32'h0);

        psel = 3'b001; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'hA5A5A5A5; PSTRB = 4'hF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_setup_ignored", {31'b0, pready[0]}, 32'd0);
        end
        psel = '0;
        PENABLE = 1'b0;
        step();
        op(0, 0, 32'h30, 32'h0, 4'h0, rd);
        chk("no_setup_word", rd, 32'h0);

        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 60; k++) begin
                r = int'($urandom_range(0, 9));
                i = (r < 1) ? int'($urandom_range(256, 300)) : int'($urandom_range(0, 15));
                a = 32'(i * 4 + ((r == 9) ? int'($urandom_range(1, 3)) : 0));
                op(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rd);
            end

        op(0, 1, 32'h44, 32'hCAFEF00D, 4'hF, rd);
        op(2, 1, 32'h44, 32'h0BADC0DE, 4'hF, rd);
        psel = 3'b001; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h44;
        step();
        PENABLE = 1'b1;
        step();
        chk("pre_rst_ready", {31'b0, pready[0]}, 32'd1);
        chk("pre_rst_data", prdata[0], 32'hCAFEF00D);
        PRESETn = 1'b0;
        step();
        chk("rst_mid_prdata", prdata[0], 32'd0);
        chk("rst_mid_pready", {31'b0, pready[0]}, 32'd0);
        chk("rst_mid_pslverr", {31'b0, pslverr[0]}, 32'd0);
        PRESETn = 1'b1;
        psel = '0;
        PENABLE = 1'b0;
        clear_model();
        step();
        op(0, 0, 32'h44, 32'h0, 4'h0, rd);
        chk("rst_mem0", rd, 32'h0);
        op(2, 0, 32'h44, 32'h0, 4'h0, rd);
        chk("rst_mem2", rd, 32'h0);
        op(1, 0, 32'h10, 32'h0, 4'h0, rd);
        chk("rst_mem1", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
